// File: rtl/dmem_pkg.sv
// Shared types and default sizes for the data-memory arbiter and its selector.
package dmem_pkg;

    localparam int DATA_WIDTH_DEF = 64;
    localparam int ADDR_WIDTH_DEF = 8;
    localparam int MEM_DEPTH_DEF  = 128;
    localparam int MAX_LOCK_DEF   = 8;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } lock_state_e;

    typedef logic port_id_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin selector: one-hot grant from requests, last winner and lock state.
module rr_pick2
    import dmem_pkg::*;
(
    input  logic [1:0]  req_i,
    input  port_id_t    last_i,
    input  lock_state_e state_i,
    output logic [1:0]  gnt_o
);

    always_comb begin
        // NOTE: default assignment first so every path drives gnt_o and no latch is inferred.
        gnt_o = 2'b00;
        case (state_i)
            LOCK0:   gnt_o = {1'b0, req_i[0]};
            LOCK1:   gnt_o = {req_i[1], 1'b0};
            default: begin
                if (req_i == 2'b11) begin
                    gnt_o = (last_i == 1'b0) ? 2'b10 : 2'b01;
                end else begin
                    gnt_o = req_i;
                end
            end
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-ported data memory between two masters with round-robin arbitration,
// bounded locked sequences and per-port read-data return one cycle after the grant.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int MEM_DEPTH  = MEM_DEPTH_DEF,
    parameter int MAX_LOCK   = MAX_LOCK_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req0,
    input  logic                  i_req1,
    input  logic                  i_we0,
    input  logic                  i_we1,
    input  logic                  i_lock0,
    input  logic                  i_lock1,
    input  logic [ADDR_WIDTH-1:0] i_addr0,
    input  logic [ADDR_WIDTH-1:0] i_addr1,
    input  logic [DATA_WIDTH-1:0] i_wdata0,
    input  logic [DATA_WIDTH-1:0] i_wdata1,
    output logic                  o_gnt0,
    output logic                  o_gnt1,
    output logic                  o_rvalid0,
    output logic                  o_rvalid1,
    output logic                  o_err0,
    output logic                  o_err1,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_mem_write,
    output logic                  o_mem_read,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    localparam int CNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(MAX_LOCK);
    localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    lock_state_e      state_q;
    port_id_t         last_q;
    logic [CNT_W-1:0] lock_cnt_q;
    logic [CNT_W-1:0] cnt_inc;

    logic     pend_valid_q, pend_valid_d;
    port_id_t pend_port_q, pend_port_d;
    logic     pend_err_q, pend_err_d;
    logic     pend_read_q, pend_read_d;

    logic [1:0]            pick;
    logic [1:0]            gnt;
    logic                  any_gnt;
    port_id_t              win;
    logic                  sel_we;
    logic                  sel_lock;
    logic                  owner_req;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  in_range;
    logic                  rd_done;

    rr_pick2 u_pick (
        .req_i   ({i_req1, i_req0}),
        .last_i  (last_q),
        .state_i (state_q),
        .gnt_o   (pick)
    );

    // Reset blanks the grant so a request seen during reset leaves no trace.
    assign gnt     = i_rst ? 2'b00 : pick;
    assign any_gnt = |gnt;
    assign win     = port_id_t'(gnt[1]);

    assign sel_we    = win ? i_we1    : i_we0;
    assign sel_lock  = win ? i_lock1  : i_lock0;
    assign sel_addr  = win ? i_addr1  : i_addr0;
    assign sel_wdata = win ? i_wdata1 : i_wdata0;
    assign in_range  = ({1'b0, sel_addr} < DEPTH_W);
    assign owner_req = (state_q == LOCK1) ? i_req1 : i_req0;
    assign cnt_inc   = lock_cnt_q + 1'b1;

    assign o_gnt0      = gnt[0];
    assign o_gnt1      = gnt[1];
    assign o_mem_write = any_gnt &  sel_we & in_range;
    assign o_mem_read  = any_gnt & ~sel_we & in_range;
    assign o_mem_addr  = any_gnt ? sel_addr  : '0;
    assign o_mem_wdata = any_gnt ? sel_wdata : '0;

    // Reads and out-of-range writes leave a tag; in-range writes complete silently.
    assign pend_valid_d = any_gnt & (~sel_we | ~in_range);
    assign pend_port_d  = win;
    assign pend_err_d   = ~in_range;
    assign pend_read_d  = ~sel_we;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pend_valid_q <= 1'b0;
            pend_port_q  <= 1'b0;
            pend_err_q   <= 1'b0;
            pend_read_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments for all sequential state so flops update together.
            pend_valid_q <= pend_valid_d;
            pend_port_q  <= pend_port_d;
            pend_err_q   <= pend_err_d;
            pend_read_q  <= pend_read_d;
        end
    end

    // Completion outputs decode straight from the tag flops; data comes from the memory's own register.
    assign rd_done   = pend_valid_q & pend_read_q;
    assign o_rvalid0 = rd_done & (pend_port_q == 1'b0);
    assign o_rvalid1 = rd_done & (pend_port_q == 1'b1);
    assign o_err0    = pend_valid_q & pend_err_q & (pend_port_q == 1'b0);
    assign o_err1    = pend_valid_q & pend_err_q & (pend_port_q == 1'b1);
    assign o_rdata   = (rd_done & ~pend_err_q) ? i_mem_rdata : '0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ARB;
            last_q     <= 1'b1;
            lock_cnt_q <= '0;
        end else begin
            if (any_gnt) begin
                last_q <= win;
            end
            case (state_q)
                ARB: begin
                    if (any_gnt && sel_lock) begin
                        state_q    <= win ? LOCK1 : LOCK0;
                        lock_cnt_q <= CNT_W'(1);
                    end
                end
                LOCK0, LOCK1: begin
                    // While locked the owner is the only grantable port, so sel_lock is the owner's lock.
                    if (!owner_req || !sel_lock || cnt_inc == CNT_MAX) begin
                        state_q    <= ARB;
                        lock_cnt_q <= '0;
                    end else begin
                        lock_cnt_q <= cnt_inc;
                    end
                end
                default: begin
                    state_q    <= ARB;
                    lock_cnt_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a registered-read memory attached.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [7:0]  addr0, addr1;
    logic [63:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [63:0] rdata;
    logic        mem_write, mem_read;
    logic [7:0]  mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic [63:0] mem [256];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .DATA_WIDTH (64),
        .ADDR_WIDTH (8),
        .MEM_DEPTH  (128),
        .MAX_LOCK   (8)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req0      (req0),
        .i_req1      (req1),
        .i_we0       (we0),
        .i_we1       (we1),
        .i_lock0     (lock0),
        .i_lock1     (lock1),
        .i_addr0     (addr0),
        .i_addr1     (addr1),
        .i_wdata0    (wdata0),
        .i_wdata1    (wdata1),
        .o_gnt0      (gnt0),
        .o_gnt1      (gnt1),
        .o_rvalid0   (rvalid0),
        .o_rvalid1   (rvalid1),
        .o_err0      (err0),
        .o_err1      (err1),
        .o_rdata     (rdata),
        .o_mem_write (mem_write),
        .o_mem_read  (mem_read),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata)
    );

    // Single-ported memory with a registered read port.
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_wdata;
        if (mem_read)  mem_rdata <= mem[mem_addr];
    end

    task automatic idle();
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        lock0 = 1'b0; lock1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic dut_write(input logic [7:0] a, input logic [63:0] d);
        @(negedge clk);
        idle();
        req0 = 1'b1; we0 = 1'b1; addr0 = a; wdata0 = d;
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle();
        rst = 1'b1;
        req0 = 1'b1; req1 = 1'b1; addr0 = 8'd1; addr1 = 8'd2;
        #1;
        n_vec++;
        if ({gnt1, gnt0} !== 2'b00) begin
            n_err++; $display("FAIL reset_gnt: got %b want 00", {gnt1, gnt0});
        end
        n_vec++;
        if ({mem_write, mem_read, mem_addr, mem_wdata} !== '0) begin
            n_err++; $display("FAIL reset_mem: got w=%b r=%b a=%h d=%h want all 0",
                              mem_write, mem_read, mem_addr, mem_wdata);
        end
        n_vec++;
        if ({rvalid1, rvalid0, err1, err0} !== 4'b0000 || rdata !== 64'd0) begin
            n_err++; $display("FAIL reset_outs: got rv=%b err=%b rdata=%h want 0",
                              {rvalid1, rvalid0}, {err1, err0}, rdata);
        end
        @(negedge clk);
        idle();
        rst = 1'b0;
    endtask

    task automatic test_single_port();
        apply_reset();
        @(negedge clk);
        idle();
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'd5; wdata0 = 64'h0000_0000_DEAD_BEEF;
        #1;
        n_vec++;
        if ({gnt1, gnt0, mem_write, mem_read, mem_addr, mem_wdata} !==
            {4'b0110, 8'd5, 64'h0000_0000_DEAD_BEEF}) begin
            n_err++; $display("FAIL single_write: got g=%b w=%b r=%b a=%h d=%h want g=01 w=1 r=0 a=05 d=deadbeef",
                              {gnt1, gnt0}, mem_write, mem_read, mem_addr, mem_wdata);
        end
        @(negedge clk);
        idle();
        req0 = 1'b1; addr0 = 8'd5;
        #1;
        n_vec++;
        if ({gnt1, gnt0, mem_write, mem_read, rvalid0, rvalid1, err0} !== 7'b0101000) begin
            n_err++; $display("FAIL single_read_grant: got g=%b w=%b r=%b rv=%b err0=%b want g=01 w=0 r=1 rv=00",
                              {gnt1, gnt0}, mem_write, mem_read, {rvalid1, rvalid0}, err0);
        end
        @(negedge clk);
        idle();
        #1;
        n_vec++;
        if ({rvalid1, rvalid0} !== 2'b01 || rdata !== 64'h0000_0000_DEAD_BEEF) begin
            n_err++; $display("FAIL single_read_data: got rv=%b rdata=%h want rv=01 rdata=deadbeef",
                              {rvalid1, rvalid0}, rdata);
        end
    endtask

    task automatic test_round_robin();
        logic [63:0] d1, d2;
        logic [1:0]  exp_g, exp_rv;
        logic [63:0] exp_d;
        d1 = 64'h1111_0000_0000_0001;
        d2 = 64'h2222_0000_0000_0002;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            idle();
            if (i < 4) begin
                req0 = 1'b1; addr0 = 8'd1;
                req1 = 1'b1; addr1 = 8'd2;
            end
            #1;
            exp_g = (i >= 4) ? 2'b00 : ((i % 2 == 0) ? 2'b01 : 2'b10);
            n_vec++;
            if ({gnt1, gnt0} !== exp_g) begin
                n_err++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, {gnt1, gnt0}, exp_g);
            end
            if (i > 0) begin
                exp_rv = ((i - 1) % 2 == 0) ? 2'b01 : 2'b10;
                exp_d  = ((i - 1) % 2 == 0) ? d1 : d2;
                n_vec++;
                if ({rvalid1, rvalid0} !== exp_rv || rdata !== exp_d) begin
                    n_err++; $display("FAIL rr_rdata[%0d]: got rv=%b rdata=%h want rv=%b rdata=%h",
                                      i, {rvalid1, rvalid0}, rdata, exp_rv, exp_d);
                end
            end
        end
    endtask

    task automatic test_lock();
        logic [1:0] exp_tab [14];
        exp_tab = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10,
                    2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b00, 2'b01};
        apply_reset();
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            idle();
            req0 = 1'b1; addr0 = 8'd3;
            if (i < 12) begin
                req1 = 1'b1; lock1 = 1'b1; addr1 = 8'd4;
            end
            #1;
            n_vec++;
            if ({gnt1, gnt0} !== exp_tab[i]) begin
                n_err++; $display("FAIL lock_gnt[%0d]: got %b want %b", i, {gnt1, gnt0}, exp_tab[i]);
            end
            if (i > 0) begin
                n_vec++;
                if ({rvalid1, rvalid0} !== exp_tab[i-1]) begin
                    n_err++; $display("FAIL lock_rvalid[%0d]: got %b want %b",
                                      i, {rvalid1, rvalid0}, exp_tab[i-1]);
                end
            end
        end
    endtask

    task automatic test_out_of_range();
        @(negedge clk);
        idle();
        req0 = 1'b1; addr0 = 8'd130;
        #1;
        n_vec++;
        if ({gnt0, mem_write, mem_read, mem_addr} !== {3'b100, 8'd130}) begin
            n_err++; $display("FAIL oor_read_drive: got g0=%b w=%b r=%b a=%0d want g0=1 w=0 r=0 a=130",
                              gnt0, mem_write, mem_read, mem_addr);
        end
        @(negedge clk);
        idle();
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'd200; wdata0 = 64'h1234;
        #1;
        n_vec++;
        if ({rvalid0, err0, rvalid1, err1} !== 4'b1100 || rdata !== 64'd0) begin
            n_err++; $display("FAIL oor_read_done: got rv0=%b err0=%b rv1=%b err1=%b rdata=%h want 1 1 0 0 0",
                              rvalid0, err0, rvalid1, err1, rdata);
        end
        n_vec++;
        if ({gnt0, mem_write, mem_read} !== 3'b100) begin
            n_err++; $display("FAIL oor_write_drive: got g0=%b w=%b r=%b want 1 0 0",
                              gnt0, mem_write, mem_read);
        end
        @(negedge clk);
        idle();
        req0 = 1'b1; addr0 = 8'd127;
        #1;
        n_vec++;
        if ({rvalid0, err0, mem_read} !== 3'b011) begin
            n_err++; $display("FAIL oor_write_done: got rv0=%b err0=%b edge_read=%b want 0 1 1",
                              rvalid0, err0, mem_read);
        end
        @(negedge clk);
        idle();
        #1;
        n_vec++;
        if ({rvalid0, err0} !== 2'b10 || rdata !== 64'h7F7F_7F7F) begin
            n_err++; $display("FAIL edge_read_data: got rv0=%b err0=%b rdata=%h want 1 0 7f7f7f7f",
                              rvalid0, err0, rdata);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        idle();
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'd9; wdata0 = 64'h55;
        #1;
        n_vec++;
        if ({gnt1, gnt0, mem_write} !== 3'b011) begin
            n_err++; $display("FAIL b2b_write: got g=%b w=%b want g=01 w=1", {gnt1, gnt0}, mem_write);
        end
        @(negedge clk);
        idle();
        req1 = 1'b1; addr1 = 8'd9;
        #1;
        n_vec++;
        if ({gnt1, gnt0, mem_read, mem_addr} !== {3'b101, 8'd9}) begin
            n_err++; $display("FAIL b2b_read: got g=%b r=%b a=%0d want g=10 r=1 a=9",
                              {gnt1, gnt0}, mem_read, mem_addr);
        end
        @(negedge clk);
        idle();
        #1;
        n_vec++;
        if ({rvalid1, rvalid0} !== 2'b10 || rdata !== 64'h55) begin
            n_err++; $display("FAIL b2b_data: got rv=%b rdata=%h want rv=10 rdata=55",
                              {rvalid1, rvalid0}, rdata);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        @(negedge clk);
        idle();
        req1 = 1'b1; lock1 = 1'b1; addr1 = 8'd4;
        #1;
        n_vec++;
        if ({gnt1, gnt0} !== 2'b10) begin
            n_err++; $display("FAIL rstmid_lock: got %b want 10", {gnt1, gnt0});
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (gnt1 !== 1'b1) begin
            n_err++; $display("FAIL rstmid_pre: got gnt1=%b want 1", gnt1);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if ({gnt1, gnt0, mem_read, rvalid1} !== 4'b0000) begin
            n_err++; $display("FAIL rstmid_assert: got g=%b r=%b rv1=%b want 0",
                              {gnt1, gnt0}, mem_read, rvalid1);
        end
        @(negedge clk);
        rst = 1'b0;
        idle();
        req0 = 1'b1; addr0 = 8'd3;
        req1 = 1'b1; lock1 = 1'b1; addr1 = 8'd4;
        #1;
        n_vec++;
        if ({gnt1, gnt0, rvalid1, rvalid0} !== 4'b0100) begin
            n_err++; $display("FAIL rstmid_release: got g=%b rv=%b want g=01 rv=00",
                              {gnt1, gnt0}, {rvalid1, rvalid0});
        end
        @(negedge clk);
        idle();
        #1;
        n_vec++;
        if ({rvalid1, rvalid0} !== 2'b01 || rdata !== 64'h3333) begin
            n_err++; $display("FAIL rstmid_after: got rv=%b rdata=%h want rv=01 rdata=3333",
                              {rvalid1, rvalid0}, rdata);
        end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        test_reset();
        dut_write(8'd1,   64'h1111_0000_0000_0001);
        dut_write(8'd2,   64'h2222_0000_0000_0002);
        dut_write(8'd3,   64'h3333);
        dut_write(8'd4,   64'h4444);
        dut_write(8'd127, 64'h7F7F_7F7F);
        test_single_port();
        test_round_robin();
        test_lock();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid();
        @(negedge clk);
        idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
